// File: rtl/imm_enc_if.sv
// imm_enc_if: request/result stream bundle between the instruction generator and imm_encoder.
interface imm_enc_if #(parameter int ERR_CNT_W = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_fmt;
  logic [31:0]          in_imm;
  logic [31:0]          in_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );
  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RISC-V I/S/B/U/J immediate packer with error counting.
// Define IMM_ENC_RANGE_CHECK_EN to enforce immediate range/alignment rules.
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input logic     clk,
  input logic     rst_n,
  imm_enc_if.slave bus
);
  logic                 r_s1_valid, r_s1_err;
  logic [2:0]           r_s1_fmt;
  logic [31:0]          r_s1_imm, r_s1_base;
  logic                 r_s2_valid, r_s2_err;
  logic [31:0]          r_s2_instr;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_s2_load, w_in_ready, w_err;
  logic [31:0]          w_mask, w_field, w_packed;
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
`ifdef IMM_ENC_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  logic               w_range_bad;
  assign w_simm = bus.in_imm;
  assign w_range_bad =
    (bus.in_fmt <= 3'd1) ? (w_simm < -2048 || w_simm > 2047) :
    (bus.in_fmt == 3'd2) ? (w_simm < -4096 || w_simm > 4094 || w_simm[0]) :
    (bus.in_fmt == 3'd3) ? (|w_simm[11:0]) :
    (bus.in_fmt == 3'd4) ? (w_simm < -1048576 || w_simm > 1048574 || w_simm[0]) :
    1'b0;
  assign w_err = bus.in_fmt > 3'd4 || w_range_bad;
`else
  assign w_err = bus.in_fmt > 3'd4;
`endif
  // Illegal formats get an empty mask so the base word passes through untouched.
  assign w_mask =
    (r_s1_fmt == 3'd0)                      ? 32'hFFF0_0000 :
    (r_s1_fmt == 3'd1 || r_s1_fmt == 3'd2) ? 32'hFE00_0F80 :
    (r_s1_fmt == 3'd3 || r_s1_fmt == 3'd4) ? 32'hFFFF_F000 :
    32'h0000_0000;
  assign w_field =
    (r_s1_fmt == 3'd0) ? {r_s1_imm[11:0], 20'd0} :
    (r_s1_fmt == 3'd1) ? {r_s1_imm[11:5], 13'd0, r_s1_imm[4:0], 7'd0} :
    (r_s1_fmt == 3'd2) ? {r_s1_imm[12], r_s1_imm[10:5], 13'd0, r_s1_imm[4:1], r_s1_imm[11], 7'd0} :
    (r_s1_fmt == 3'd3) ? {r_s1_imm[31:12], 12'd0} :
    {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], 12'd0};
  assign w_packed = (r_s1_base & ~w_mask) | (r_s1_err ? 32'd0 : w_field);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_fmt   <= 3'd0;
      r_s1_imm   <= 32'd0;
      r_s1_base  <= 32'd0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_instr <= 32'd0;
      r_err_cnt  <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_err  <= w_err;
          r_s1_fmt  <= bus.in_fmt;
          r_s1_imm  <= bus.in_imm;
          r_s1_base <= bus.in_base;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_packed;
          r_s2_err   <= r_s1_err;
        end
      end
      if (r_s2_valid && bus.out_ready && r_s2_err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_instr = r_s2_instr;
  assign bus.out_err   = r_s2_err;
  assign bus.err_count = r_err_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against a bit-map reference model.
module tb_imm_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_enc_if #(.ERR_CNT_W(8)) bus ();
  imm_encoder #(.ERR_CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Which immediate bit lands in instruction bit p, or -1 if p belongs to the base word.
  function automatic int src_bit(input logic [2:0] f, input int p);
    case (f)
      3'd0: return p >= 20 ? p - 20 : -1;
      3'd1: return p >= 25 ? p - 20 : (p >= 7 && p <= 11) ? p - 7 : -1;
      3'd2: return p == 31 ? 12 : p >= 25 ? p - 20 : (p >= 8 && p <= 11) ? p - 7 : p == 7 ? 11 : -1;
      3'd3: return p >= 12 ? p : -1;
      3'd4: return p == 31 ? 20 : p >= 21 ? p - 20 : p == 20 ? 11 : p >= 12 ? p : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
    int v;
    bit err;
    logic [31:0] r;
    v = $signed(imm);
    err = f > 3'd4;
`ifdef IMM_ENC_RANGE_CHECK_EN
    case (f)
      3'd0, 3'd1: err = v < -2048 || v > 2047;
      3'd2: err = v < -4096 || v > 4094 || (v % 2 != 0);
      3'd3: err = (imm % 4096) != 0;
      3'd4: err = v < -1048576 || v > 1048574 || (v % 2 != 0);
      default: err = 1'b1;
    endcase
`endif
    for (int p = 0; p < 32; p++) begin
      int s;
      s = src_bit(f, p);
      r[p] = (s < 0) ? base[p] : (err ? 1'b0 : imm[s]);
    end
    return {err, r};
  endfunction

  // Handshakes are predicted at the negedge; inputs are stable from posedge+2 to the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_fmt, bus.in_imm, bus.in_base));
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_err, bus.out_instr});
    end
  end

  task automatic push(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_fmt = f;
    bus.in_imm = imm;
    bus.in_base = base;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1 ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_timeout: request fmt=%0d never accepted, in_ready=%b required 1", f, bus.in_ready);
    end
  endtask

  task automatic drain(input int target);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 500 && got_q.size() < target; n++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (got_q.size() != target) begin
      n_fail++;
      $display("FAIL drain_count: delivered %0d results, required %0d", got_q.size(), target);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_fmt = 3'd0;
    bus.in_imm = 32'd0;
    bus.in_base = 32'd0;
    bus.out_ready = 1'b1;
    #1;
    n_tests += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr: got %h required 0", bus.out_instr); end
    if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b required 0", bus.out_err); end
    if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d required 0", bus.err_count); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] want[4] = '{32'hFFB00013, 32'hFFFFF06F, 32'h00000463, 32'h12345037};
    int g0 = got_q.size();
    bus.in_valid = 1'b1;
    bus.in_fmt = 3'd0;
    bus.in_imm = -32'sd5;
    bus.in_base = 32'h00000013;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: out_valid=%b one edge after accept, required 0", bus.out_valid); end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFB00013 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_i: valid=%b instr=%h err=%b, required 1 FFB00013 0", bus.out_valid, bus.out_instr, bus.out_err);
    end
    push(3'd4, -32'sd2, 32'h0000006F);
    push(3'd2, 32'd8, 32'h00000063);
    push(3'd3, 32'h12345000, 32'h00000037);
    drain(g0 + 4);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== {1'b0, want[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d: got %h required %h", i, got_q.size() > g0 + i ? got_q[g0 + i] : 33'h0, {1'b0, want[i]});
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  f[4]  = '{3'd4, 3'd2, 3'd3, 3'd6};
    logic [31:0] im[4] = '{32'h00100000, 32'd3, 32'h12345001, 32'd0};
    logic [31:0] bs[4] = '{32'h0000006F, 32'h00000063, 32'h00000037, 32'hDEADBEEF};
`ifdef IMM_ENC_RANGE_CHECK_EN
    logic [32:0] want[4] = '{{1'b1, 32'h0000006F}, {1'b1, 32'h00000063}, {1'b1, 32'h00000037}, {1'b1, 32'hDEADBEEF}};
    logic [7:0]  want_cnt = 8'd4;
`else
    logic [32:0] want[4] = '{{1'b0, 32'h8000006F}, {1'b0, 32'h00000163}, {1'b0, 32'h12345037}, {1'b1, 32'hDEADBEEF}};
    logic [7:0]  want_cnt = 8'd1;
`endif
    int g0;
    pulse_reset();
    g0 = got_q.size();
    for (int i = 0; i < 4; i++) push(f[i], im[i], bs[i]);
    drain(g0 + 4);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== want[i]) begin
        n_fail++;
        $display("FAIL error_case_%0d: got %h required %h", i, got_q.size() > g0 + i ? got_q[g0 + i] : 33'h0, want[i]);
      end
    end
    n_tests++;
    if (bus.err_count !== want_cnt) begin n_fail++; $display("FAIL err_count: got %0d required %0d", bus.err_count, want_cnt); end
  endtask

  task automatic test_back_to_back();
    int g0 = got_q.size();
    int e0 = exp_q.size();
    int c0 = cyc;
    for (int i = 0; i < 8; i++) push(3'd0, 32'($urandom_range(0, 4095)) - 32'd2048, $urandom);
    n_tests++;
    if (cyc - c0 != 8) begin n_fail++; $display("FAIL throughput: 8 requests took %0d cycles, required 8", cyc - c0); end
    drain(g0 + 8);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_q[e0 + i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h required %h", i, got_q.size() > g0 + i ? got_q[g0 + i] : 33'h0, exp_q[e0 + i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  f[3];
    logic [31:0] im[3], bs[3];
    logic [31:0] held;
    int acc = 0;
    int g0 = got_q.size();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      f[i] = 3'($urandom_range(0, 4));
      im[i] = 32'($urandom_range(0, 2047)) & ~32'h1;
      bs[i] = $urandom;
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_fmt = f[acc];
      bus.in_imm = im[acc];
      bus.in_base = bs[acc];
      #1 ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) acc++;
      if (c == 1) held = bus.out_instr;
    end
    n_tests += 4;
    if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: accepted %0d while stalled, required 2", acc); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b1 || bus.out_instr !== model(f[0], im[0], bs[0]) ) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b instr=%h required 1 %h", bus.out_valid, bus.out_instr, model(f[0], im[0], bs[0]));
    end
    if (bus.out_instr !== held) begin n_fail++; $display("FAIL bp_stable: instr %h changed from %h", bus.out_instr, held); end
    bus.out_ready = 1'b1;
    push(f[2], im[2], bs[2]);
    drain(g0 + 3);
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (got_q.size() != g0 + 3) begin n_fail++; $display("FAIL bp_dup: delivered %0d, required %0d", got_q.size() - g0, 3); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== model(f[i], im[i], bs[i])) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got %h required %h", i, got_q.size() > g0 + i ? got_q[g0 + i] : 33'h0, model(f[i], im[i], bs[i]));
      end
    end
  endtask

  function automatic logic [31:0] rand_imm();
    int b[13] = '{-2048, 2047, 2048, -2049, 4094, 4095, 4096, -4096, -4098, 1048574, 1048576, -1048576, -1048578};
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 8191)) - 32'd4096;
      1: return 32'(b[$urandom_range(0, 12)]);
      2: return $urandom;
      default: return $urandom_range(0, 1) ? ($urandom & ~32'hFFF) : 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endfunction

  task automatic test_random();
    int g0, e0, errs;
    bit done = 1'b0;
    logic [7:0] want_cnt;
    pulse_reset();
    g0 = got_q.size();
    e0 = exp_q.size();
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push($urandom_range(0, 1) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)), rand_imm(), $urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    drain(g0 + 600);
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      n_tests++;
      if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_q[e0 + i]) begin
        n_fail++;
        $display("FAIL random_%0d: got %h required %h", i, got_q.size() > g0 + i ? got_q[g0 + i] : 33'h0, exp_q[e0 + i]);
      end
      errs += int'(exp_q[e0 + i][32]);
    end
    want_cnt = errs > 255 ? 8'd255 : 8'(errs);
    n_tests++;
    if (bus.err_count !== want_cnt) begin n_fail++; $display("FAIL random_err_count: got %0d required %0d", bus.err_count, want_cnt); end
  endtask

  task automatic test_reset_midstream();
    int g0 = got_q.size();
    bus.out_ready = 1'b0;
    push(3'd0, 32'd1, 32'h13);
    push(3'd6, 32'd0, 32'hDEADBEEF);
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full: out_valid=%b required 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL mid_out_instr: got %h required 0", bus.out_instr); end
    if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL mid_out_err: got %b required 0", bus.out_err); end
    if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL mid_err_count: got %0d required 0", bus.err_count); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid: got %b required 0", bus.out_valid); end
    if (got_q.size() != g0) begin n_fail++; $display("FAIL mid_stale_delivery: delivered %0d, required 0", got_q.size() - g0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
